// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Conditions a raw, bouncing push-button into a clean debounced level plus
//   one-cycle event pulses: press, release, long-press and auto-repeat.
//
//   Pipeline: 2-flop synchronizer -> debounce counter -> press/release FSM.
//   All event pulses are registered and mutually exclusive; a release always
//   wins over a long-press or repeat event falling on the same cycle.
//
//   Configuration macro:
//     BTN_AUTOREPEAT_EN  - when defined, builds the repeat counter and drives
//                          repeat_tick; when undefined, repeat_tick is tied 0.
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int CLK_FREQ    = 100_000_000,  // clock frequency in Hz
  parameter int DEBOUNCE_MS = 20,           // stable time before level changes
  parameter int HOLD_MS     = 600,          // press time before long-press
  parameter int REPEAT_MS   = 150           // auto-repeat interval
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick
);

  // ---------------------------------------------------------------------------
  // Derived cycle counts and counter widths
  // ---------------------------------------------------------------------------
  localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HOLD_CYC = CLK_FREQ / 1000 * HOLD_MS;
  localparam int REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;

  // A terminal count of 1 still needs one counter bit to exist.
  localparam int DB_W   = (DB_CYC   > 1) ? $clog2(DB_CYC)   : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  // Zero-length intervals would make the counters meaningless.
  if (DB_CYC < 1) begin : g_db_cyc_check
    $error("btn_conditioner: DB_CYC must be at least 1");
  end
  if (HOLD_CYC < 1) begin : g_hold_cyc_check
    $error("btn_conditioner: HOLD_CYC must be at least 1");
  end
  if (REP_CYC < 1) begin : g_rep_cyc_check
    $error("btn_conditioner: REP_CYC must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Types and signals
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_btn_level;
  logic              w_differ;
  logic              w_toggle;
  logic              w_rise;
  logic              w_fall;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_hold_done;

  logic              w_press_nxt;
  logic              w_release_nxt;
  logic              w_long_nxt;
  logic              r_press_tick;
  logic              r_release_tick;
  logic              r_long_tick;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;

  logic [REP_W-1:0]  r_rep_cnt;
  logic              w_rep_done;
  logic              w_repeat_nxt;
  logic              r_repeat_tick;
`endif

  // ---------------------------------------------------------------------------
  // Debounce datapath
  // ---------------------------------------------------------------------------
  // Synchronizer output disagrees with the current debounced level.
  assign w_differ = r_sync2 ^ r_btn_level;
  // Level flips on the edge where the disagreement has lasted DB_CYC cycles.
  assign w_toggle = w_differ && (r_db_cnt == DB_W'(DB_CYC - 1));
  assign w_rise   = w_toggle && !r_btn_level;
  assign w_fall   = w_toggle &&  r_btn_level;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample pre-edge values;
      // blocking ones here would collapse the synchronizer into a single stage.
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter: runs while input and level disagree, flips the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt    <= '0;
      r_btn_level <= 1'b0;
    end else if (w_toggle) begin
      r_db_cnt    <= '0;
      r_btn_level <= ~r_btn_level;
    end else if (w_differ) begin
      r_db_cnt    <= r_db_cnt + DB_W'(1);
    end else begin
      r_db_cnt    <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Press / hold / repeat FSM
  // ---------------------------------------------------------------------------
  // Hold counter reads k exactly k cycles after the press edge.
  assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_CYC - 1));

`ifdef BTN_AUTOREPEAT_EN
  assign w_rep_done = (r_state == ST_LONG) && (r_rep_cnt == REP_W'(REP_CYC - 1));
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RELEASED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-tick decode; release always wins over long/repeat.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_repeat_nxt  = 1'b0;
`endif
    unique case (r_state)
      ST_RELEASED: begin
        if (w_rise) begin
          w_state_nxt = ST_HELD;
          w_press_nxt = 1'b1;
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          w_state_nxt   = ST_RELEASED;
          w_release_nxt = 1'b1;
        end else if (w_hold_done) begin
          w_state_nxt = ST_LONG;
          w_long_nxt  = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          w_state_nxt   = ST_RELEASED;
          w_release_nxt = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (w_rep_done) begin
          w_repeat_nxt = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_RELEASED;
      end
    endcase
  end

  // Hold counter: zero outside HELD, so it starts from 0 on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_HELD) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end else begin
      r_hold_cnt <= '0;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Repeat counter: free-runs in LONG and wraps every REP_CYC cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt <= '0;
    end else if ((r_state == ST_LONG) && !w_rep_done) begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end else begin
      r_rep_cnt <= '0;
    end
  end
`endif

  // Registered event pulses, aligned with the debounced level change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_press_tick   <= 1'b0;
      r_release_tick <= 1'b0;
      r_long_tick    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_repeat_tick  <= 1'b0;
`endif
    end else begin
      r_press_tick   <= w_press_nxt;
      r_release_tick <= w_release_nxt;
      r_long_tick    <= w_long_nxt;
`ifdef BTN_AUTOREPEAT_EN
      r_repeat_tick  <= w_repeat_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign btn_level    = r_btn_level;
  assign press_tick   = r_press_tick;
  assign release_tick = r_release_tick;
  assign long_tick    = r_long_tick;
`ifdef BTN_AUTOREPEAT_EN
  assign repeat_tick  = r_repeat_tick;
`else
  assign repeat_tick  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Self-checking bench for btn_conditioner with small timing parameters.
//   A behavioural model (sample queue, run-length debounce, press-age rules)
//   predicts every output after every clock edge; directed scenarios add
//   latency and event-count checks. Honours BTN_AUTOREPEAT_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int CLK_FREQ    = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int HOLD_MS     = 20;
  localparam int REPEAT_MS   = 5;

  localparam int DB   = CLK_FREQ / 1000 * DEBOUNCE_MS;  // 4
  localparam int HOLD = CLK_FREQ / 1000 * HOLD_MS;      // 20
  localparam int REP  = CLK_FREQ / 1000 * REPEAT_MS;    // 5

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic btn_in;
  logic btn_level;
  logic press_tick;
  logic release_tick;
  logic long_tick;
  logic repeat_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit samp_q[$];     // raw samples still in flight through the synchronizer
  bit m_lvl;
  int m_run;         // consecutive cycles the synchronized input disagreed
  bit m_held;
  int m_press_e;
  bit x_press, x_release, x_long, x_repeat;
  int ecount;        // clock edges since reset was released

  // Observed events
  int n_press, n_release, n_long, n_rep;
  int e_press, e_release, e_long;
  int rep_q[$];
  int start_e;

  btn_conditioner #(
    .CLK_FREQ    (CLK_FREQ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .HOLD_MS     (HOLD_MS),
    .REPEAT_MS   (REPEAT_MS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_tick   (press_tick),
    .release_tick (release_tick),
    .long_tick    (long_tick),
    .repeat_tick  (repeat_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    samp_q.push_back(1'b0);
    samp_q.push_back(1'b0);
    m_lvl     = 1'b0;
    m_run     = 0;
    m_held    = 1'b0;
    m_press_e = 0;
  endtask

  // Advance the model by one clock edge that sampled raw value b.
  task automatic model_edge(input bit b);
    bit d;
    int age;
    d = samp_q.pop_front();   // value sampled two edges ago
    samp_q.push_back(b);
    x_press = 0; x_release = 0; x_long = 0; x_repeat = 0;
    if (d != m_lvl) begin
      m_run++;
      if (m_run >= DB) begin
        m_lvl     = d;
        m_run     = 0;
        x_press   = m_lvl;
        x_release = !m_lvl;
      end
    end else begin
      m_run = 0;
    end
    if (x_press) begin
      m_held    = 1'b1;
      m_press_e = ecount;
    end
    if (x_release) m_held = 1'b0;
    age = ecount - m_press_e;
    if (m_held && !x_press) begin
      x_long   = (age == HOLD);
      x_repeat = REPEAT_ON && (age > HOLD) && (((age - HOLD) % REP) == 0);
    end
  endtask

  task automatic clear_obs();
    n_press = 0; n_release = 0; n_long = 0; n_rep = 0;
    e_press = -1000; e_release = -1000; e_long = -1000;
    rep_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"},   btn_level,    0);
    check({tag, "_press"},   press_tick,   0);
    check({tag, "_release"}, release_tick, 0);
    check({tag, "_long"},    long_tick,    0);
    check({tag, "_repeat"},  repeat_tick,  0);
  endtask

  // Drive one raw sample, clock it in, then compare against the model.
  task automatic step(input bit b);
    btn_in = b;
    @(posedge clk);
    #1;
    ecount++;
    model_edge(b);
    check("btn_level",    btn_level,    m_lvl);
    check("press_tick",   press_tick,   x_press);
    check("release_tick", release_tick, x_release);
    check("long_tick",    long_tick,    x_long);
    check("repeat_tick",  repeat_tick,  x_repeat);
    if (press_tick)   begin n_press++;   e_press   = ecount; end
    if (release_tick) begin n_release++; e_release = ecount; end
    if (long_tick)    begin n_long++;    e_long    = ecount; end
    if (repeat_tick)  begin n_rep++;     rep_q.push_back(ecount); end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  initial begin
    bit lv;
    int len;

    // Reset state
    reset_n = 1'b0;
    btn_in  = 1'b0;
    ecount  = 0;
    model_reset();
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    #3 reset_n = 1'b1;
    idle(5);

    // Clean press followed by a long hold
    clear_obs();
    start_e = ecount + 1;
    repeat (50) step(1'b1);
    check("clean_press_count",   n_press, 1);
    check("clean_press_latency", e_press - start_e + 1, DB + 2);
    check("hold_long_count",     n_long, 1);
    check("hold_long_offset",    e_long - e_press, HOLD);
`ifdef BTN_AUTOREPEAT_EN
    check("hold_rep_enough", rep_q.size() >= 3, 1);
    if (rep_q.size() >= 3) begin
      check("hold_rep0_offset", rep_q[0] - e_press, HOLD + REP);
      check("hold_rep1_offset", rep_q[1] - e_press, HOLD + 2 * REP);
      check("hold_rep2_offset", rep_q[2] - e_press, HOLD + 3 * REP);
    end
`else
    check("hold_rep_none", n_rep, 0);
`endif
    idle(12);
    check("hold_release_count", n_release, 1);
    check("hold_long_once",     n_long, 1);

    // Short glitch: three high cycles must produce nothing
    clear_obs();
    repeat (3) step(1'b1);
    idle(15);
    check("glitch_events", n_press + n_release + n_long + n_rep, 0);
    check("glitch_level",  btn_level, 0);

    // Release while still in HELD
    clear_obs();
    for (int i = 0; i < 20 && n_press == 0; i++) step(1'b1);
    check("held_press_seen", n_press, 1);
    repeat (10) step(1'b1);
    idle(15);
    check("held_release_count", n_release, 1);
    check("held_no_long",       n_long, 0);

    // Bounce 1-0-1-0 every 2 cycles, then stable high
    clear_obs();
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    start_e = ecount + 1;
    repeat (12) step(1'b1);
    check("bounce_press_count",   n_press, 1);
    check("bounce_press_latency", e_press - start_e + 1, DB + 2);
    idle(12);

    // Reset mid-hold while in LONG, button kept pressed
    clear_obs();
    repeat (30) step(1'b1);
    check("rst_reached_long", n_long, 1);
    #2 reset_n = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    #3 reset_n = 1'b1;
    clear_obs();
    start_e = ecount + 1;
    repeat (10) step(1'b1);
    check("rst_press_count",   n_press, 1);
    check("rst_press_latency", e_press - start_e + 1, DB + 2);
    check("rst_no_release",    n_release, 0);
    idle(12);

    // Randomized segments checked against the model
    for (int s = 0; s < 150; s++) begin
      lv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 6);
      else                           len = $urandom_range(1, 45);
      repeat (len) step(lv);
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, stable time required before the debounced level changes.
REQ-003 SHALL have parameter HOLD_MS, default 600, continuous press time before long-press is reported.
REQ-004 SHALL have parameter REPEAT_MS, default 150, auto-repeat interval after long-press.
REQ-005 SHALL have port clk  input  1  system clock; all logic runs in this single clock domain.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port btn_in  input  1  raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-008 SHALL have port btn_level  output  1  debounced button level.
REQ-009 SHALL have port press_tick  output  1  one-cycle pulse when btn_level rises; feeds the timer/stopwatch button inputs.
REQ-010 SHALL have port release_tick  output  1  one-cycle pulse when btn_level falls.
REQ-011 SHALL have port long_tick  output  1  one-cycle pulse, issued once per press, when the hold time is reached.
REQ-012 SHALL have port repeat_tick  output  1  one-cycle auto-repeat pulse while the button stays held after long_tick.

Function
REQ-013 SHALL derive cycle counts DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS, HOLD_CYC = CLK_FREQ/1000*HOLD_MS and REP_CYC = CLK_FREQ/1000*REPEAT_MS.
REQ-014 SHALL size each counter with $clog2 of its own terminal count, and SHALL require DB_CYC, HOLD_CYC and REP_CYC all to be at least 1.
REQ-015 SHALL pass btn_in through a 2-flop synchronizer before any other use.
REQ-016 SHALL increment the debounce counter while the synchronized input differs from btn_level, and clear it on any cycle where they are equal.
REQ-017 SHALL toggle btn_level and clear the debounce counter when the counter reaches DB_CYC-1 while the inputs still differ.
REQ-018 SHALL make a glitch shorter than DB_CYC cycles produce no output activity.
REQ-019 SHALL assert press_tick in the first cycle btn_level is 1, and release_tick in the first cycle btn_level is 0.
REQ-020 SHALL make press latency exactly DB_CYC+2 cycles from the first clock edge that samples btn_in high, given clean input.
REQ-021 SHALL implement an FSM with states RELEASED, HELD, LONG:
- RELEASED -> HELD on a rising edge of btn_level.
- HELD -> LONG when the hold counter reaches HOLD_CYC.
- HELD or LONG -> RELEASED on a falling edge of btn_level.
REQ-022 SHALL clear the hold counter on entry to HELD, and assert long_tick exactly HOLD_CYC cycles after the press_tick cycle.
REQ-023 SHALL assert repeat_tick in LONG every REP_CYC cycles, the first one REP_CYC cycles after long_tick.
REQ-024 SHALL give release priority when a release and a long or repeat event fall on the same cycle: release_tick fires and long_tick/repeat_tick are suppressed.
REQ-025 SHALL never assert more than one of press_tick, release_tick, long_tick and repeat_tick in the same cycle.
REQ-026 SHALL produce a press_tick, with normal latency, after reset deasserts if btn_in is held high throughout reset.

Reset
REQ-027 SHALL clear on reset_n=0, immediately: the synchronizer, all counters and btn_level; set the FSM to RELEASED; drive every output to 0.
REQ-028 SHALL abort any press in progress when reset is asserted mid-press, with no release_tick emitted.

Configuration
REQ-029 SHALL compile in the REP_CYC counter and repeat_tick generation when macro BTN_AUTOREPEAT_EN is defined.
REQ-030 SHALL, without BTN_AUTOREPEAT_EN, omit the repeat counter and tie repeat_tick to constant 0; long_tick behaviour is unchanged.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4, HOLD_MS=20, REPEAT_MS=5)
REQ-031 SHALL cover a clean press: btn_in 0->1 sampled at cycle 0 -> press_tick high only in cycle 6, and btn_level=1 from cycle 6.
REQ-032 SHALL cover a glitch: btn_in high for 3 cycles, then low -> no tick at all and btn_level stays 0.
REQ-033 SHALL cover a long hold: press_tick at cycle P and btn_in held -> long_tick at P+20; with the macro, repeat_tick at P+25, P+30, P+35; without it, repeat_tick stays 0.
REQ-034 SHALL cover release during HELD: release after 10 cycles held -> release_tick once, and no long_tick.
REQ-035 SHALL cover reset mid-hold: reset_n pulsed low in LONG with btn_in still high -> all outputs 0 immediately; after reset_n returns high, press_tick DB_CYC+2 = 6 cycles later.
REQ-036 SHALL cover bounce: 1-0-1-0 toggles every 2 cycles, then stable high -> exactly one press_tick, 6 cycles after the last rising edge.
